// File: rtl/bootrom_flash_loader_if.sv
// Signal bundle between the boot flash loader, its requester, the SPI flash pins and boot memory.
interface bootrom_flash_loader_if;
  logic        start;
  logic [23:0] flash_addr;
  logic [14:0] length;
  logic        busy;
  logic        done;
  logic        flash_cs_n;
  logic        flash_clk;
  logic        flash_mosi;
  logic        flash_miso;
  logic [13:0] mem_a;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  checksum;

  modport slave (
    input  start, flash_addr, length, flash_miso,
    output busy, done, flash_cs_n, flash_clk, flash_mosi, mem_a, mem_din, mem_we, checksum
  );

  modport master (
    output start, flash_addr, length, flash_miso,
    input  busy, done, flash_cs_n, flash_clk, flash_mosi, mem_a, mem_din, mem_we, checksum
  );
endinterface

// File: rtl/bootrom_flash_loader.sv
// Copies bytes from SPI flash (READ 0x03, mode 0, CLKDIV clk per SCK half-period) into boot memory.
// Define ROM_LOADER_CHECKSUM_EN to get a running byte sum on checksum; otherwise it is tied to 0.
module bootrom_flash_loader #(
  parameter int unsigned CLKDIV    = 1,
  parameter int unsigned MEM_DEPTH = 16384
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bootrom_flash_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DESEL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0]  DIV_LAST = 8'(CLKDIV - 1);
  localparam logic [14:0] DEPTH    = 15'(MEM_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic [31:0] cmd_q, cmd_d;
  logic [4:0]  bit_q, bit_d;
  logic [6:0]  rx_q, rx_d;
  logic [14:0] len_q, len_d;
  logic [14:0] idx_q, idx_d;
  logic [1:0]  dly_q, dly_d;
  logic        we_q, we_d;
  logic [13:0] a_q, a_d;
  logic [7:0]  din_q, din_d;
  logic        tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    cmd_d   = cmd_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    len_d   = len_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    we_d    = 1'b0;
    a_d     = a_q;
    din_d   = din_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d = (bus.length > DEPTH) ? DEPTH : bus.length;
          idx_d = '0;
          if (bus.length == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CMD;
            cs_n_d  = 1'b0;
            cmd_d   = {8'h03, bus.flash_addr};
            bit_d   = '0;
            div_d   = '0;
            sclk_d  = 1'b0;
          end
        end
      end

      S_CMD, S_DATA: begin
        div_d = tick ? 8'd0 : div_q + 8'd1;
        if (tick) begin
          sclk_d = ~sclk_q;
        end
        // Rising SCK edge: sample MISO; the completed byte is written in the following cycle.
        if (tick && !sclk_q && state_q == S_DATA) begin
          rx_d = {rx_q[5:0], bus.flash_miso};
          if (bit_q[2:0] == 3'd7) begin
            we_d  = 1'b1;
            a_d   = idx_q[13:0];
            din_d = {rx_q, bus.flash_miso};
            idx_d = idx_q + 15'd1;
          end
        end
        // Falling SCK edge: advance MOSI, or close the transfer once the final bit period ends.
        if (tick && sclk_q) begin
          if (state_q == S_CMD) begin
            cmd_d = {cmd_q[30:0], 1'b0};
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              state_d = S_DATA;
            end
          end else begin
            bit_d = {2'b00, bit_q[2:0] + 3'd1};
            if (bit_q[2:0] == 3'd7 && idx_q == len_q) begin
              state_d = S_DESEL;
              cs_n_d  = 1'b1;
              sclk_d  = 1'b0;
              dly_d   = '0;
            end
          end
        end
      end

      S_DESEL: begin
        dly_d = dly_q + 2'd1;
        if (dly_q == 2'd3) begin
          state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      cmd_q   <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      dly_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      cmd_q   <= cmd_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      we_q    <= we_d;
      a_q     <= a_d;
      din_q   <= din_d;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      sum_q <= '0;
    end else if (we_d) begin
      sum_q <= sum_q + din_d;
    end
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = 8'h00;
`endif

  // MOSI is the command register MSB; it shifts only on falling SCK and is zero once drained.
  assign bus.flash_mosi = cmd_q[31];
  assign bus.flash_clk  = sclk_q;
  assign bus.flash_cs_n = cs_n_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_a      = a_q;
  assign bus.mem_din    = din_q;
  assign bus.busy       = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_DESEL);
  assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_bootrom_flash_loader.sv
// Bench: two loaders (CLKDIV=1/MEM_DEPTH=64 and CLKDIV=3/MEM_DEPTH=16384) against a byte-level flash model.
module tb_bootrom_flash_loader;
  localparam int CD0  = 1;
  localparam int CD1  = 3;
  localparam int DEP0 = 64;
  localparam int DEP1 = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_r [2] = '{default: 1'b0};
  logic [23:0] addr_r  [2] = '{default: 24'h0};
  logic [14:0] len_r   [2] = '{default: 15'h0};
  logic        miso_r  [2] = '{default: 1'b0};
  logic        busy_w [2], done_w [2], cs_w [2], sck_w [2], mosi_w [2], we_w [2];
  logic [13:0] a_w   [2];
  logic [7:0]  din_w [2];
  logic [7:0]  ck_w  [2];

  for (genvar g = 0; g < 2; g++) begin : gi
    bootrom_flash_loader_if bus ();
    assign bus.start      = start_r[g];
    assign bus.flash_addr = addr_r[g];
    assign bus.length     = len_r[g];
    assign bus.flash_miso = miso_r[g];
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign cs_w[g]   = bus.flash_cs_n;
    assign sck_w[g]  = bus.flash_clk;
    assign mosi_w[g] = bus.flash_mosi;
    assign we_w[g]   = bus.mem_we;
    assign a_w[g]    = bus.mem_a;
    assign din_w[g]  = bus.mem_din;
    assign ck_w[g]   = bus.checksum;

    bootrom_flash_loader #(
      .CLKDIV   ((g == 0) ? CD0 : CD1),
      .MEM_DEPTH((g == 0) ? DEP0 : DEP1)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents seen at byte address A are fmem[A[7:0]].
  logic [7:0]  fmem [256];
  int          wr_n [2] = '{default: 0};
  int          done_n [2] = '{default: 0};
  int unsigned done_at [2] = '{default: 0};
  int          cs_lo [2] = '{default: 0};
  int          hi_runs [2] = '{default: 0};
  int          ph_bad [2] = '{default: 0};
  int          we_cs_hi [2] = '{default: 0};
  int          nb [2] = '{default: 0};
  int          run [2] = '{default: 0};
  logic        lvl [2] = '{default: 1'b0};
  logic        in_cs [2] = '{default: 1'b0};
  logic        sck_p [2] = '{default: 1'b0};
  logic [31:0] cmd_r [2] = '{default: 32'h0};
  logic [13:0] wr_a [2][1024];
  logic [7:0]  wr_d [2][1024];
  int          m_cd, m_k;
  logic [7:0]  m_ix, m_fb;

  // Monitor plus SPI flash model, all sampled mid-cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      m_cd = (g == 0) ? CD0 : CD1;
      if (we_w[g]) begin
        wr_a[g][wr_n[g] % 1024] = a_w[g];
        wr_d[g][wr_n[g] % 1024] = din_w[g];
        wr_n[g] = wr_n[g] + 1;
        if (cs_w[g]) we_cs_hi[g] = we_cs_hi[g] + 1;
      end
      if (done_w[g]) begin
        done_n[g]  = done_n[g] + 1;
        done_at[g] = cyc;
      end
      if (!cs_w[g]) begin
        cs_lo[g] = cs_lo[g] + 1;
        if (in_cs[g] && sck_w[g] == lvl[g]) begin
          run[g] = run[g] + 1;
        end else begin
          if (in_cs[g]) begin
            if (run[g] != m_cd) ph_bad[g] = ph_bad[g] + 1;
            if (lvl[g]) hi_runs[g] = hi_runs[g] + 1;
          end
          lvl[g] = sck_w[g];
          run[g] = 1;
        end
        in_cs[g] = 1'b1;
        if (sck_w[g] && !sck_p[g]) begin
          if (nb[g] < 32) cmd_r[g] = {cmd_r[g][30:0], mosi_w[g]};
          nb[g] = nb[g] + 1;
        end
        if (!sck_w[g] && nb[g] >= 32) begin
          m_k  = nb[g] - 32;
          m_ix = cmd_r[g][7:0] + 8'(m_k / 8);
          m_fb = fmem[m_ix];
          miso_r[g] = m_fb[7 - (m_k % 8)];
        end
      end else begin
        if (in_cs[g]) begin
          if (run[g] != m_cd) ph_bad[g] = ph_bad[g] + 1;
          if (lvl[g]) hi_runs[g] = hi_runs[g] + 1;
        end
        in_cs[g] = 1'b0;
        nb[g] = 0;
      end
      sck_p[g] = sck_w[g];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_flash();
    for (int i = 0; i < 256; i++) fmem[i] = 8'($urandom);
  endtask

  task automatic run_copy(input int g, input logic [23:0] a, input logic [14:0] l, input int poke);
    int n, w0, d0, h0, p0, c0, e0, lim, cd, dep, bits, got_n;
    int unsigned sc;
    logic [7:0] sum, eb, ix, ce;
    cd   = (g == 0) ? CD0 : CD1;
    dep  = (g == 0) ? DEP0 : DEP1;
    n    = (int'(l) > dep) ? dep : int'(l);
    bits = 32 + 8 * n;
    w0 = wr_n[g]; d0 = done_n[g]; h0 = hi_runs[g]; p0 = ph_bad[g]; c0 = cs_lo[g]; e0 = we_cs_hi[g];
    @(posedge clk); #1;
    start_r[g] = 1'b1; addr_r[g] = a; len_r[g] = l; sc = cyc;
    @(posedge clk); #1;
    start_r[g] = 1'b0; addr_r[g] = 24'($urandom); len_r[g] = 15'($urandom);
    chk("busy_after_start", busy_w[g], n != 0);
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1; start_r[g] = 1'b1; addr_r[g] = ~a; len_r[g] = l + 15'd3;
      @(posedge clk); #1; start_r[g] = 1'b0;
    end
    lim = bits * 2 * cd + 50;
    for (int i = 0; i < lim && done_n[g] == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", done_n[g] - d0, 1);
    chk("done_latency", done_at[g] - sc, (n == 0) ? 1 : bits * 2 * cd + 5);
    got_n = wr_n[g] - w0;
    chk("write_count", got_n, n);
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      ix  = a[7:0] + 8'(i);
      eb  = fmem[ix];
      sum = sum + eb;
      if (i < got_n) begin
        chk("write_addr", wr_a[g][(w0 + i) % 1024], 14'(i));
        chk("write_data", wr_d[g][(w0 + i) % 1024], eb);
      end
    end
    if (n > 0) chk("mosi_command", cmd_r[g], {8'h03, a});
    chk("cs_low_cycles", cs_lo[g] - c0, (n == 0) ? 0 : bits * 2 * cd);
    chk("sck_bit_periods", hi_runs[g] - h0, (n == 0) ? 0 : bits);
    chk("sck_phase_len", ph_bad[g] - p0, 0);
    chk("we_outside_data", we_cs_hi[g] - e0, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    ce = sum;
`else
    ce = 8'h00;
`endif
    chk("checksum", ck_w[g], ce);
    chk("idle_after_done", {busy_w[g], cs_w[g], sck_w[g]}, 3'b010);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("reset_state",
          {busy_w[g], done_w[g], cs_w[g], sck_w[g], mosi_w[g], we_w[g], a_w[g], din_w[g], ck_w[g]},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 8'h00, 8'h00});
    end
    rst_n = 1'b1;

    fill_flash();
    fmem[0] = 8'hA5; fmem[1] = 8'h5A; fmem[2] = 8'h00; fmem[3] = 8'hFF;
    run_copy(0, 24'h07C000, 15'd4, 0);

    run_copy(0, 24'h123456, 15'd0, 0);

    repeat (3) begin
      fill_flash();
      run_copy(0, 24'($urandom), 15'($urandom_range(1, 6)), 0);
    end

    fill_flash();
    run_copy(0, 24'($urandom), 15'd20000, 0);
    chk("clamp_last_addr", a_w[0], 14'(DEP0 - 1));

    fill_flash();
    run_copy(1, 24'($urandom), 15'd2, 0);

    fill_flash();
    run_copy(0, 24'($urandom), 15'd5, 20);

    // Reset in the middle of a 10-byte copy, after its second write.
    fill_flash();
    w0 = wr_n[0];
    @(posedge clk); #1;
    start_r[0] = 1'b1; addr_r[0] = 24'($urandom); len_r[0] = 15'd10;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    for (int i = 0; i < 2000 && (wr_n[0] - w0) < 2; i++) begin
      @(posedge clk); #2;
    end
    chk("abort_two_writes", wr_n[0] - w0, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs_n", cs_w[0], 1'b1);
    chk("abort_busy", busy_w[0], 1'b0);
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("abort_no_more_we", wr_n[0] - w0, 2);
    chk("abort_checksum", ck_w[0], 8'h00);

    fill_flash();
    run_copy(0, 24'($urandom), 15'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
